// File: rtl/rom_stream_reader.sv
// Walks a programmed ROM address range and streams the words out on a valid/ready
// interface with a per-pass last marker; supports one-shot and looping playback.
module rom_stream_reader #(
    parameter  int WIDTH = 1,
    parameter  int SIZE  = 1,
    localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [AW-1:0]    START_ADDR,
    input  logic [AW:0]      COUNT,
    input  logic             LOOP,
    input  logic             STOP,
    output logic [AW-1:0]    ROM_ADDR,
    input  logic [WIDTH-1:0] ROM_DO,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] TOP     = AW'(SIZE - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW-1:0]    base_q, base_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      rem_q, rem_d;
    logic             loop_q, loop_d;
    logic             stop_q, stop_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [AW-1:0]    ptr_next;

    // Wrap at SIZE, which need not be a power of two.
    assign ptr_next = (ptr_q == TOP) ? '0 : ptr_q + AW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        count_d = count_q;
        rem_d   = rem_q;
        loop_d  = loop_q;
        stop_d  = stop_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (COUNT == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        base_d  = START_ADDR;
                        ptr_d   = START_ADDR;
                        count_d = COUNT;
                        rem_d   = COUNT;
                        loop_d  = LOOP;
                        stop_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (loop_q && STOP)
                    stop_d = 1'b1;
                // Output register refills when empty or when its word leaves this cycle.
                if (!valid_q || OUT_READY) begin
                    data_d  = ROM_DO;
                    valid_d = 1'b1;
                    last_d  = (rem_q == REM_ONE);
                    if (rem_q == REM_ONE) begin
                        if (!loop_q || stop_q || STOP) begin
                            state_d = S_DRAIN;
                            rem_d   = '0;
                            ptr_d   = ptr_next;
                        end else begin
                            ptr_d  = base_q;
                            rem_d  = count_q;
                            stop_d = 1'b0;
                        end
                    end else begin
                        ptr_d = ptr_next;
                        rem_d = rem_q - REM_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (OUT_READY) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            base_q  <= '0;
            count_q <= '0;
            rem_q   <= '0;
            loop_q  <= 1'b0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            loop_q  <= loop_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign ROM_ADDR  = ptr_q;
    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign OUT_LAST  = last_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench: two readers (SIZE=16 and SIZE=10) against a list-based
// reference of expected words built from base/count/passes with modular addressing.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start16 = 1'b0, start10 = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] count = '0;
    logic       loop_i = 1'b0, stop_i = 1'b0, ready = 1'b0;

    logic [3:0] addr16, addr10;
    logic [7:0] do16, do10, data16, data10;
    logic       valid16, valid10, last16, last10, busy16, busy10, done16, done10;

    always #5 clk = ~clk;

    // ROM contents: word i = i*0x11
    assign do16 = {addr16, addr16};
    assign do10 = {addr10, addr10};

    rom_stream_reader #(.WIDTH(8), .SIZE(16)) u16 (
        .CLK(clk), .RST(rst), .START(start16), .START_ADDR(start_addr), .COUNT(count),
        .LOOP(loop_i), .STOP(stop_i), .ROM_ADDR(addr16), .ROM_DO(do16),
        .OUT_DATA(data16), .OUT_VALID(valid16), .OUT_READY(ready), .OUT_LAST(last16),
        .BUSY(busy16), .DONE(done16));

    rom_stream_reader #(.WIDTH(8), .SIZE(10)) u10 (
        .CLK(clk), .RST(rst), .START(start10), .START_ADDR(start_addr), .COUNT(count),
        .LOOP(loop_i), .STOP(stop_i), .ROM_ADDR(addr10), .ROM_DO(do10),
        .OUT_DATA(data10), .OUT_VALID(valid10), .OUT_READY(ready), .OUT_LAST(last10),
        .BUSY(busy10), .DONE(done10));

    typedef struct {
        bit s;
        int addr;
        int cnt;
        bit lp;
        int stop_at;
        int rdy;
        bit poke;
        int passes;
    } vec_t;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    function automatic int exp_word(input int a);
        return (a * 17) & 255;
    endfunction

    // Monitor on the selected DUT
    bit         sel = 1'b0;
    logic       m_v, m_l, m_done, m_busy;
    logic [7:0] m_d;
    assign m_v    = sel ? valid10 : valid16;
    assign m_l    = sel ? last10  : last16;
    assign m_d    = sel ? data10  : data16;
    assign m_done = sel ? done10  : done16;
    assign m_busy = sel ? busy10  : busy16;

    int cyc = 0;
    int wq[$], lq[$], tq[$];
    int done_n = 0, done_cyc = 0, busy_at_done = 0;
    bit any_valid = 1'b0;

    initial begin
        bit       pv = 1'b0, pr = 1'b0, pl = 1'b0;
        bit [7:0] pd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", int'(m_v), 1);
                    chk("hold_data", int'(m_d), int'(pd));
                    chk("hold_last", int'(m_l), int'(pl));
                end
                if (m_v) any_valid = 1'b1;
                if (m_v && ready) begin
                    wq.push_back(int'(m_d));
                    lq.push_back(int'(m_l));
                    tq.push_back(cyc);
                end
                if (m_done) begin
                    if (done_n == 0) begin
                        done_cyc     = cyc;
                        busy_at_done = int'(m_busy);
                    end
                    done_n++;
                end
                pv = m_v; pr = ready; pd = m_d; pl = m_l;
            end
        end
    end

    function automatic bit pick_ready(input int pct);
        return (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
    endfunction

    task automatic play(input vec_t v);
        int  start_neg, total, sz;
        bit  stopped;
        sel = v.s;
        wq.delete(); lq.delete(); tq.delete();
        done_n = 0; any_valid = 1'b0;
        @(posedge clk); #1;
        start_addr = 4'(v.addr); count = 5'(v.cnt); loop_i = v.lp;
        ready = pick_ready(v.rdy);
        if (v.s) start10 = 1'b1; else start16 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0; start16 = 1'b0;
        start_neg = cyc + 1;
        chk("busy_after_start", int'(v.s ? busy10 : busy16), int'(v.cnt > 0));
        stopped = 1'b0;
        for (int k = 0; k < 400 && done_n == 0; k++) begin
            @(posedge clk); #1;
            ready = pick_ready(v.rdy);
            if (v.poke && k == 2) begin
                start_addr = 4'd0; count = 5'd2; loop_i = 1'b1;
                if (v.s) start10 = 1'b1; else start16 = 1'b1;
            end else begin
                start10 = 1'b0; start16 = 1'b0;
            end
            if (v.stop_at > 0 && !stopped && wq.size() >= v.stop_at) begin
                stop_i = 1'b1; stopped = 1'b1;
            end else begin
                stop_i = 1'b0;
            end
        end
        stop_i = 1'b0; start10 = 1'b0; start16 = 1'b0;
        chk("done_seen", int'(done_n > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        sz    = v.s ? 10 : 16;
        total = v.cnt * v.passes;
        chk("word_count", wq.size(), total);
        for (int i = 0; i < wq.size() && i < total; i++) begin
            chk("data", wq[i], exp_word((v.addr + i % v.cnt) % sz));
            chk("last", lq[i], int'((i % v.cnt) == v.cnt - 1));
        end
        chk("done_pulses", done_n, 1);
        chk("busy_at_done", busy_at_done, 0);
        if (v.cnt == 0) begin
            chk("done_latency", done_cyc, start_neg);
            chk("no_valid", int'(any_valid), 0);
        end else if (v.rdy >= 100 && tq.size() > 0) begin
            chk("first_latency", tq[0], start_neg + 1);
            for (int i = 1; i < tq.size(); i++) chk("no_bubble", tq[i], tq[0] + i);
            chk("done_after_last", done_cyc, tq[tq.size()-1] + 1);
        end
    endtask

    initial begin
        vec_t vecs[12];
        vec_t rv;
        vecs[0]  = '{0,  3,  4, 0, 0, 100, 0, 1};
        vecs[1]  = '{1,  8,  5, 0, 0, 100, 0, 1};
        vecs[2]  = '{0,  0, 16, 0, 0,  50, 0, 1};
        vecs[3]  = '{0,  0,  0, 0, 0, 100, 0, 1};
        vecs[4]  = '{0,  5,  8, 0, 0, 100, 1, 1};
        vecs[5]  = '{0,  3,  3, 1, 3, 100, 0, 2};
        vecs[6]  = '{0, 10,  3, 1, 4, 100, 0, 2};
        vecs[7]  = '{0,  0,  3, 1, 1, 100, 0, 1};
        vecs[8]  = '{0, 12,  2, 1, 1, 100, 0, 2};
        vecs[9]  = '{0, 14,  4, 1, 3, 100, 0, 2};
        vecs[10] = '{0, 15, 16, 0, 0, 100, 0, 1};
        vecs[11] = '{1,  9, 10, 0, 0,  70, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid16), 0);
        chk("rst_busy", int'(busy16), 0);
        chk("rst_done", int'(done16), 0);
        chk("rst_addr", int'(addr16), 0);
        chk("rst_valid10", int'(valid10), 0);
        rst = 1'b0;

        foreach (vecs[i]) play(vecs[i]);

        // Reset mid-run with a stalled word held
        sel = 1'b0;
        @(posedge clk); #1;
        ready = 1'b0; start_addr = 4'd2; count = 5'd8; loop_i = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_valid", int'(valid16), 1);
        chk("pre_reset_data", int'(data16), 'h22);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_valid", int'(valid16), 0);
        chk("arst_last", int'(last16), 0);
        chk("arst_data", int'(data16), 0);
        chk("arst_busy", int'(busy16), 0);
        chk("arst_done", int'(done16), 0);
        chk("arst_addr", int'(addr16), 0);
        rst = 1'b0; ready = 1'b1; done_n = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_n, 0);
        play(vecs[0]);

        // Randomized one-shots
        for (int r = 0; r < 8; r++) begin
            rv.s       = 1'($urandom_range(0, 1));
            rv.addr    = int'($urandom_range(0, rv.s ? 9 : 15));
            rv.cnt     = int'($urandom_range(1, rv.s ? 10 : 16));
            rv.lp      = 1'b0;
            rv.stop_at = 0;
            rv.rdy     = 50;
            rv.poke    = 1'b0;
            rv.passes  = 1;
            play(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
